// File: rtl/clock_time_controller_if.sv
// clock_time_controller_if: tick/button inputs and time/display outputs of the time controller.
interface clock_time_controller_if #(parameter int W = 6);
  logic         tick;
  logic         btn_mode;
  logic         btn_inc;
  logic [W-1:0] sec;
  logic [W-1:0] min;
  logic [W-1:0] hour;
  logic [1:0]   mode;
  logic         blank_sec;
  logic         blank_min;
  logic         blank_hour;
  logic         min_carry;
  logic         hour_carry;
  logic         day_wrap;
  modport master (
    output tick, btn_mode, btn_inc,
    input  sec, min, hour, mode, blank_sec, blank_min, blank_hour, min_carry, hour_carry, day_wrap
  );
  modport slave (
    input  tick, btn_mode, btn_inc,
    output sec, min, hour, mode, blank_sec, blank_min, blank_hour, min_carry, hour_carry, day_wrap
  );
endinterface

// File: rtl/clock_time_controller.sv
// clock_time_controller: HH:MM:SS timekeeping with same-edge carries and a button-driven set mode
// whose selected field blinks on the tick.
module clock_time_controller #(
  parameter int W        = 6,
  parameter int SEC_MAX  = 59,
  parameter int MIN_MAX  = 59,
  parameter int HOUR_MAX = 23
) (
  input logic                    clk,
  input logic                    rst,
  clock_time_controller_if.slave bus
);
  typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN, SET_SEC} state_t;
  localparam logic [W-1:0] S_MAX = W'(SEC_MAX);
  localparam logic [W-1:0] M_MAX = W'(MIN_MAX);
  localparam logic [W-1:0] H_MAX = W'(HOUR_MAX);
  state_t       state_q, state_d;
  logic [W-1:0] sec_q, sec_d, min_q, min_d, hour_q, hour_d;
  logic         blink_q, blink_d;
  logic [2:0]   blank_q, blank_d;
  logic [2:0]   carry_q, carry_d;
  logic         s_wrap, m_wrap, h_wrap, edit;
  assign s_wrap = sec_q == S_MAX;
  assign m_wrap = min_q == M_MAX;
  assign h_wrap = hour_q == H_MAX;
  // a mode press in the same cycle swallows the edit
  assign edit   = bus.btn_inc && !bus.btn_mode;
  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    blink_d = blink_q;
    carry_d = '0;
    case (state_q)
      RUN: if (bus.tick) begin
        sec_d      = s_wrap ? '0 : sec_q + W'(1);
        carry_d[0] = s_wrap;
        carry_d[1] = s_wrap && m_wrap;
        carry_d[2] = s_wrap && m_wrap && h_wrap;
        min_d      = s_wrap ? (m_wrap ? '0 : min_q + W'(1)) : min_q;
        hour_d     = (s_wrap && m_wrap) ? (h_wrap ? '0 : hour_q + W'(1)) : hour_q;
      end
      SET_HOUR: hour_d = edit ? (h_wrap ? '0 : hour_q + W'(1)) : hour_q;
      SET_MIN:  min_d  = edit ? (m_wrap ? '0 : min_q + W'(1)) : min_q;
      default:  sec_d  = edit ? '0 : sec_q;
    endcase
    // entering any state restarts the blink visible
    state_d = bus.btn_mode ? state_t'(state_q + 2'd1) : state_q;
    blink_d = bus.btn_mode ? 1'b0 : (state_q != RUN && bus.tick) ? ~blink_q : blink_q;
    blank_d = {state_d == SET_HOUR && blink_d, state_d == SET_MIN && blink_d, state_d == SET_SEC && blink_d};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
      blink_q <= 1'b0;
      blank_q <= '0;
      carry_q <= '0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      blink_q <= blink_d;
      blank_q <= blank_d;
      carry_q <= carry_d;
    end
  end
  assign bus.sec        = sec_q;
  assign bus.min        = min_q;
  assign bus.hour       = hour_q;
  assign bus.mode       = state_q;
  assign bus.blank_hour = blank_q[2];
  assign bus.blank_min  = blank_q[1];
  assign bus.blank_sec  = blank_q[0];
  assign bus.min_carry  = carry_q[0];
  assign bus.hour_carry = carry_q[1];
  assign bus.day_wrap   = carry_q[2];
endmodule

// File: tb/tb_clock_time_controller.sv
// tb_clock_time_controller: scenario tasks plus randomized pulses checked against a
// seconds-of-day reference model.
module tb_clock_time_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  int t, md;
  bit bl, mc, hc, dw;
  clock_time_controller_if #(.W(6)) bus();
  clock_time_controller #(.W(6), .SEC_MAX(59), .MIN_MAX(59), .HOUR_MAX(23)) dut (
    .clk(clk), .rst(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;

  function automatic logic [25:0] obs();
    return {bus.sec, bus.min, bus.hour, bus.mode, bus.blank_hour, bus.blank_min, bus.blank_sec,
            bus.min_carry, bus.hour_carry, bus.day_wrap};
  endfunction

  function automatic logic [25:0] expv();
    return {6'(t % 60), 6'((t / 60) % 60), 6'(t / 3600), 2'(md), md == 1 && bl, md == 2 && bl,
            md == 3 && bl, mc, hc, dw};
  endfunction

  task automatic model_reset();
    t = 0; md = 0; bl = 0; mc = 0; hc = 0; dw = 0;
  endtask

  task automatic model_step(input bit tk, input bit m, input bit inc);
    int h, mm;
    mc = 0; hc = 0; dw = 0;
    h = t / 3600;
    mm = (t / 60) % 60;
    if (md == 0 && tk) begin
      mc = (t % 60) == 59;
      hc = (t % 3600) == 3599;
      dw = t == 86399;
      t = (t + 1) % 86400;
    end else if (md == 1 && inc && !m) t = t - h * 3600 + ((h + 1) % 24) * 3600;
    else if (md == 2 && inc && !m) t = t - mm * 60 + ((mm + 1) % 60) * 60;
    else if (md == 3 && inc && !m) t = t - t % 60;
    if (m) begin
      md = (md + 1) % 4;
      bl = 0;
    end else if (md != 0 && tk) bl = !bl;
  endtask

  task automatic cyc(input bit tk, input bit m, input bit inc);
    @(negedge clk);
    bus.tick = tk; bus.btn_mode = m; bus.btn_inc = inc;
    @(posedge clk);
    model_step(tk, m, inc);
    #1;
    bus.tick = 0; bus.btn_mode = 0; bus.btn_inc = 0;
  endtask

  task automatic test_reset();
    bus.tick = 0; bus.btn_mode = 0; bus.btn_inc = 0;
    rst_n = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (obs() !== 26'h0) begin fails++; $display("FAIL reset got=%h exp=%h", obs(), 26'h0); end
    @(negedge clk);
    rst_n = 1;
    cyc(0, 0, 0);
    tests++;
    if (obs() !== expv()) begin fails++; $display("FAIL reset_release got=%h exp=%h", obs(), expv()); end
  endtask

  task automatic test_run_61();
    int n_mc = 0;
    for (int i = 0; i < 61; i++) begin
      repeat ($urandom_range(0, 2)) begin
        cyc(0, 0, 1'($urandom_range(0, 1)));
        n_mc += int'(bus.min_carry);
        tests++;
        if (obs() !== expv()) begin fails++; $display("FAIL run_idle i=%0d got=%h exp=%h", i, obs(), expv()); end
      end
      cyc(1, 0, 1'($urandom_range(0, 1)));
      n_mc += int'(bus.min_carry);
      tests++;
      if (obs() !== expv()) begin fails++; $display("FAIL run_tick i=%0d got=%h exp=%h", i, obs(), expv()); end
      if (i == 59) begin
        tests++;
        if (bus.min_carry !== 1'b1) begin fails++; $display("FAIL run_min_carry got=%b exp=1", bus.min_carry); end
      end
    end
    tests++;
    if ({bus.sec, bus.min, bus.hour} !== {6'd1, 6'd1, 6'd0})
      begin fails++; $display("FAIL run_61 got=%0d:%0d:%0d exp=0:1:1", bus.hour, bus.min, bus.sec); end
    tests++;
    if (n_mc != 1) begin fails++; $display("FAIL run_carry_count got=%0d exp=1", n_mc); end
  endtask

  task automatic test_day_wrap();
    cyc(0, 1, 0);
    while (t / 3600 != 23) cyc(0, 0, 1);
    cyc(0, 1, 0);
    while ((t / 60) % 60 != 59) cyc(0, 0, 1);
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    cyc(0, 1, 0);
    repeat (59) cyc(1, 0, 0);
    tests++;
    if (obs() !== {6'd59, 6'd59, 6'd23, 2'd0, 6'b0})
      begin fails++; $display("FAIL preload got=%h exp=%h", obs(), {6'd59, 6'd59, 6'd23, 2'd0, 6'b0}); end
    cyc(1, 0, 0);
    tests++;
    if (obs() !== {18'd0, 2'd0, 3'b0, 3'b111})
      begin fails++; $display("FAIL day_wrap got=%h exp=%h", obs(), {18'd0, 2'd0, 3'b0, 3'b111}); end
    cyc(0, 0, 0);
    tests++;
    if (obs() !== 26'h0) begin fails++; $display("FAIL day_wrap_pulse got=%h exp=%h", obs(), 26'h0); end
  endtask

  task automatic test_set_hour();
    bit saw23 = 0;
    bit wrapped = 0;
    repeat (42) cyc(1, 0, 0);
    cyc(0, 1, 0);
    tests++;
    if ({bus.mode, bus.blank_hour} !== 3'b010)
      begin fails++; $display("FAIL set_hour_entry got=%b exp=010", {bus.mode, bus.blank_hour}); end
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 1)) begin
        cyc(1, 0, 0);
        tests++;
        if (obs() !== expv()) begin fails++; $display("FAIL set_hour_tick i=%0d got=%h exp=%h", i, obs(), expv()); end
      end
      cyc(1'($urandom_range(0, 1)), 0, 1);
      if (saw23 && bus.hour == 0) wrapped = 1;
      saw23 = bus.hour == 23;
      tests++;
      if (obs() !== expv()) begin fails++; $display("FAIL set_hour_inc i=%0d got=%h exp=%h", i, obs(), expv()); end
    end
    tests++;
    if ({bus.mode, bus.hour, bus.min, bus.sec, wrapped} !== {2'd1, 6'd1, 6'd0, 6'd42, 1'b1})
      begin fails++; $display("FAIL set_hour_final got=m%0d %0d:%0d:%0d w%0d exp=m1 1:0:42 w1", bus.mode, bus.hour, bus.min, bus.sec, wrapped); end
  endtask

  task automatic test_simultaneous();
    cyc(0, 1, 1);
    tests++;
    if ({bus.mode, bus.hour} !== {2'd2, 6'd1})
      begin fails++; $display("FAIL mode_inc got=m%0d h%0d exp=m2 h1", bus.mode, bus.hour); end
    while ((t / 60) % 60 != 59) cyc(0, 0, 1);
    cyc(0, 0, 1);
    tests++;
    if ({bus.min, bus.hour} !== {6'd0, 6'd1})
      begin fails++; $display("FAIL min_wrap got=%0d:%0d exp=1:0", bus.hour, bus.min); end
    cyc(0, 1, 0);
    tests++;
    if ({bus.mode, bus.sec} !== {2'd3, 6'd42})
      begin fails++; $display("FAIL set_sec_entry got=m%0d s%0d exp=m3 s42", bus.mode, bus.sec); end
    cyc(1, 0, 0);
    tests++;
    if (obs() !== expv()) begin fails++; $display("FAIL set_sec_blink got=%h exp=%h", obs(), expv()); end
    cyc(0, 0, 1);
    tests++;
    if (bus.sec !== 6'd0) begin fails++; $display("FAIL sec_clear got=%0d exp=0", bus.sec); end
    cyc(1, 1, 0);
    tests++;
    if ({bus.mode, bus.sec, bus.blank_sec} !== {2'd0, 6'd0, 1'b0})
      begin fails++; $display("FAIL mode_tick_sec got=m%0d s%0d b%0d exp=m0 s0 b0", bus.mode, bus.sec, bus.blank_sec); end
    cyc(1, 0, 0);
    tests++;
    if (bus.sec !== 6'd1) begin fails++; $display("FAIL resume got=%0d exp=1", bus.sec); end
    cyc(1, 1, 0);
    tests++;
    if ({bus.mode, bus.sec} !== {2'd1, 6'd2})
      begin fails++; $display("FAIL run_mode_tick got=m%0d s%0d exp=m1 s2", bus.mode, bus.sec); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
      tests++;
      if (obs() !== expv()) begin fails++; $display("FAIL random i=%0d got=%h exp=%h", i, obs(), expv()); end
    end
  endtask

  task automatic test_async_reset();
    while (md != 0) cyc(0, 1, 0);
    repeat (5) cyc(1, 0, 0);
    #3;
    rst_n = 0;
    #1;
    model_reset();
    tests++;
    if (obs() !== 26'h0) begin fails++; $display("FAIL async_reset got=%h exp=%h", obs(), 26'h0); end
    @(negedge clk);
    rst_n = 1;
    cyc(0, 0, 0);
    tests++;
    if (obs() !== 26'h0) begin fails++; $display("FAIL after_reset got=%h exp=%h", obs(), 26'h0); end
    cyc(1, 0, 0);
    tests++;
    if (obs() !== {6'd1, 20'd0}) begin fails++; $display("FAIL first_tick got=%h exp=%h", obs(), {6'd1, 20'd0}); end
  endtask

  initial begin
    test_reset();
    test_run_61();
    test_day_wrap();
    test_set_hour();
    test_simultaneous();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/clock_time_controller.md
Name: clock_time_controller

Overview:
- Timekeeping and time-set controller for the HH:MM:SS display chain. It sequences the seconds, minutes and hours fields from a 1 Hz tick and resolves all carries in the same cycle.
- A button-driven FSM lets the user set each field. It also drives per-field blanking so the field being edited blinks.
- It sits between the clock divider (tick source) and the BCD/7-segment decoders (which take sec/min/hour).

Parameters:
- W, 6, width of each time field.
- SEC_MAX, 59, last seconds value before wrap.
- MIN_MAX, 59, last minutes value before wrap.
- HOUR_MAX, 23, last hours value before wrap.

Ports:
- clk  input  1  system clock (CLOCK_50 domain).
- rst  input  1  asynchronous reset, active-low.
- tick  input  1  one-cycle pulse, 1 Hz, synchronous to clk.
- btn_mode  input  1  one-cycle pulse, already debounced and synchronized; advances the FSM.
- btn_inc  input  1  one-cycle pulse, already debounced and synchronized; edits the selected field.
- sec  output  W  seconds, binary, 0..SEC_MAX.
- min  output  W  minutes, binary, 0..MIN_MAX.
- hour  output  W  hours, binary, 0..HOUR_MAX.
- mode  output  2  FSM state: 0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC.
- blank_sec, blank_min, blank_hour  output  1 each  display blank request for that field (1 = blank).
- min_carry  output  1  one-cycle pulse when seconds wrap into minutes.
- hour_carry  output  1  one-cycle pulse when minutes wrap into hours.
- day_wrap  output  1  one-cycle pulse when 23:59:59 rolls over to 00:00:00.

Behaviour:
- All outputs are registered. Reset (rst=0, async) forces:
  - sec=min=hour=0, mode=RUN;
  - all blank_* = 0, all carry pulses = 0;
  - blink phase = 0.
  Release is sampled synchronously on the next clk edge.
- Latency: an input pulse sampled at edge N is reflected in the outputs after edge N, i.e. one cycle.
- FSM transitions on btn_mode: RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN. No other transitions.
- RUN:
  - On tick, sec increments.
  - If sec==SEC_MAX: sec=0 and min increments in the same edge.
  - If min==MIN_MAX too: min=0 and hour increments in the same edge.
  - If hour==HOUR_MAX too: hour=0.
  - Carries therefore take effect without lag: 00:00:59 plus tick gives 00:01:00 in one edge.
  - btn_inc is ignored in RUN.
- Carry pulses are asserted only in RUN, for exactly one cycle, coincident with the updated values:
  - min_carry on a seconds wrap;
  - hour_carry on a minutes wrap;
  - day_wrap on an hours wrap.
- SET_HOUR / SET_MIN:
  - tick does not advance time.
  - btn_inc adds 1 to the selected field, wrapping MAX -> 0.
  - No carry into other fields; no carry pulses.
- SET_SEC: btn_inc clears sec to 0. tick does not advance time.
- Blink:
  - The blink phase toggles on every tick in set states.
  - On any entry into a set state it is forced to 0, so the field is visible immediately.
  - blank_<selected field> = blink phase; the other blank_* outputs are 0.
  - In RUN, all blank_* = 0.
- Simultaneous events:
  - btn_mode and btn_inc in the same cycle: the mode change wins and btn_inc is dropped.
  - btn_mode and tick in the same cycle in RUN: the tick is applied, then the state becomes SET_HOUR.
  - btn_mode and tick in SET_SEC: the state becomes RUN and the tick is discarded; counting resumes on the next tick.
- Values never exceed their MAX. The comparisons are ==MAX, so out-of-range values are unreachable after reset.
- Reset mid-operation (any state, any pulse in flight) returns to the reset values in the same instant; no pulse is emitted.

Test Plan:
- Reset then 61 ticks in RUN -> sec=1, min=1, hour=0. min_carry is seen exactly once, in the cycle after the 60th tick.
- Preload 23:59:59 via set mode, return to RUN, 1 tick -> 00:00:00 one cycle later. min_carry, hour_carry and day_wrap are each high for that single cycle.
- btn_mode x1, btn_inc x25 -> mode=1, hour=1 (wrap 23->0 observed), min and sec unchanged, no carry pulses. Ticks during this do not change sec, and blank_hour toggles on each tick starting from 0.
- In SET_MIN with min=59, btn_inc -> min=0 and hour unchanged. Then in SET_SEC with sec=42, btn_inc -> sec=0.
- btn_mode and btn_inc in the same cycle in SET_HOUR -> mode=2 and hour unchanged. btn_mode and tick in the same cycle in SET_SEC -> mode=0 and sec unchanged.
- Assert rst low asynchronously mid-count (between edges) -> all outputs reach their reset values immediately. After release, the first tick gives sec=1.
